axi_lite_slave_mem: RTL and testbench
=====================================

Name: axi_lite_slave_mem

Overview:
- Byte-wide memory responder: the target end of the team's simplified AXI-style read/write burst interface driven by the bus master block.
- Accepts read address bursts and returns data beats with RLAST.
- Accepts write address plus data bursts terminated by WLAST, and returns a write response.
- Read and write channels are independent FSMs sharing one memory array.

Parameters:
- MEM_DEPTH, 256, number of implemented bytes (1..256); addresses >= MEM_DEPTH are out of range.
- MAX_BEATS, 16, maximum write beats stored per burst.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- ARVALID  in  1  read address valid
- AR_IN  in  16  [15:8] ARADDR, [7:4] ARLEN (beats-1), [3:0] ARID
- ARREADY  out  1  one-cycle read address accept pulse
- RVALID  out  1  read beat valid
- RREADY  in  1  master ready for read beat
- ROUT  out  9  [8:1] read data, [0] RRESP (1 = error)
- RLAST  out  1  final read beat
- RID  out  4  ARID of the current burst
- AWVALID  in  1  write address valid
- AW_IN  in  12  [11:4] AWADDR, [3:0] AWID
- AWREADY  out  1  one-cycle write address accept pulse
- WVALID  in  1  write beat valid
- WDATA  in  8  write data
- WLAST  in  1  final write beat
- WREADY  out  1  ready for write beats
- BVALID  out  1  write response valid
- BREADY  in  1  master ready for response
- BRESP  out  5  [4:1] BID (= AWID), [0] error

Behaviour:
- Reset (sync): all outputs 0, both FSMs to IDLE, internal counters 0.
- Reset: memory contents are not cleared.
- Reset asserted mid-burst aborts the burst; no response is issued.
- Read FSM, R_IDLE:
  - On ARVALID, latch addr/len/id, set ARREADY=1, go to R_ACK.
  - ARREADY is high for exactly one cycle.
- Read FSM, R_ACK:
  - ARREADY=0, RVALID=1.
  - ROUT = {mem[addr], 0} if in range, else {8'h00, 1}.
  - RLAST = (len==0), RID = id. Go to R_DATA.
  - First data is therefore visible 2 cycles after ARVALID is sampled.
- Read FSM, R_DATA:
  - Beat transfers on RVALID && RREADY. RVALID holds and ROUT is stable until the transfer.
  - On transfer with RLAST: RVALID=0, RLAST=0, ROUT=0, go to R_IDLE.
  - On transfer otherwise: addr+1 (8-bit wrap 0xFF->0x00), beat+1, load next beat the following cycle, RLAST=(beat==len).
  - A burst contains exactly len+1 beats, 1..16.
- Write FSM, W_IDLE:
  - On AWVALID, latch addr/id, AWREADY=1, clear err and beat counter, go to W_ACK.
- Write FSM, W_ACK:
  - AWREADY=0, WREADY=1, go to W_DATA.
  - WREADY never overlaps AWREADY.
- Write FSM, W_DATA:
  - Beat accepted on WVALID && WREADY.
  - Memory is written only if addr < MEM_DEPTH and beat < MAX_BEATS; otherwise err=1 and the data is dropped.
  - Each accepted beat: addr+1 with 8-bit wrap, beat+1 (saturating).
  - On the WLAST beat: WREADY=0, BVALID=1, BRESP={id, err_final}, go to W_RESP. err_final includes that last beat.
- Write FSM, W_RESP:
  - Hold BVALID and BRESP until BREADY.
  - On BREADY: BVALID=0, BRESP=0, go to W_IDLE.
  - The next AWVALID is accepted no earlier than the following cycle.
- Channel concurrency:
  - Both channels run concurrently.
  - Same-cycle write and read-load of the same address: the read returns the old value (write commits at the clock edge).
- Handshake rules:
  - ARVALID/AWVALID are ignored outside IDLE.
  - WVALID is ignored outside W_DATA.

Test Plan:
- Write 3-beat burst: AWADDR=0x10, AWID=0x5, data A1,B2,C3 with WLAST on the 3rd beat -> AWREADY pulses 1 cycle, then WREADY=1; 3 beats stored at 0x10..0x12; BVALID=1 with BRESP=5'b0101_0, cleared after BREADY.
- Read back: AR_IN={0x10,4'h2,4'h3} with RREADY held high -> ARREADY pulse, RVALID 2 cycles after ARVALID; ROUT data A1,B2,C3 with RRESP=0 on consecutive cycles; RLAST only on C3; RID=3; then RVALID=0.
- Address wrap and out-of-range: MEM_DEPTH=8 read of 2 beats at 0x07 -> beat0 = mem[7] with resp 0, beat1 = {00,1}. With MEM_DEPTH=256, write 2 beats at 0xFF -> stored at 0xFF and 0x00.
- Backpressure: read of 4 beats with RREADY toggling 1,0,0,1,... -> ROUT and RVALID stable while RREADY=0; exactly 4 transfers; no skipped or duplicated beat.
- Overlong write: 18 beats without WLAST until the 18th -> only the first 16 stored; BRESP[0]=1. Concurrent read of an unrelated address meanwhile completes normally.
- Reset mid-read (beat 2 of 5) and mid-write -> next cycle all outputs 0, FSMs idle; a new ARVALID is accepted immediately after rst deasserts.

Source files
------------

// File: rtl/axi_lite_slave_mem_if.sv
// rtl/axi_lite_slave_mem_if.sv - burst read/write bus between the master block and the memory responder
interface axi_lite_slave_mem_if;
    logic        ARVALID;
    logic [15:0] AR_IN;
    logic        ARREADY;
    logic        RVALID;
    logic        RREADY;
    logic [8:0]  ROUT;
    logic        RLAST;
    logic [3:0]  RID;
    logic        AWVALID;
    logic [11:0] AW_IN;
    logic        AWREADY;
    logic        WVALID;
    logic [7:0]  WDATA;
    logic        WLAST;
    logic        WREADY;
    logic        BVALID;
    logic        BREADY;
    logic [4:0]  BRESP;

    modport slave (
        input  ARVALID, AR_IN, RREADY, AWVALID, AW_IN, WVALID, WDATA, WLAST, BREADY,
        output ARREADY, RVALID, ROUT, RLAST, RID, AWREADY, WREADY, BVALID, BRESP
    );

    modport master (
        output ARVALID, AR_IN, RREADY, AWVALID, AW_IN, WVALID, WDATA, WLAST, BREADY,
        input  ARREADY, RVALID, ROUT, RLAST, RID, AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// rtl/axi_lite_slave_mem.sv - byte-wide memory responder with independent read and write burst FSMs
module axi_lite_slave_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int MAX_BEATS = 16
) (
    input  logic                clk,
    input  logic                rst,
    axi_lite_slave_mem_if.slave bus
);
    localparam int              IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int              WB_W      = $clog2(MAX_BEATS + 1);
    localparam logic [8:0]      DEPTH_LIM = 9'(MEM_DEPTH);
    localparam logic [WB_W-1:0] BEAT_LIM  = WB_W'(MAX_BEATS);

    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ACK, W_DATA, W_RESP} w_state_t;

    logic [7:0] mem [MEM_DEPTH];

    r_state_t   r_state, r_next;
    logic [7:0] r_addr, r_addr_nxt;
    logic [3:0] r_len, r_beat, r_id, r_id_out;
    logic [8:0] r_out, rd_cur, rd_nxt;
    logic       r_last;

    w_state_t        w_state, w_next;
    logic [7:0]      w_addr;
    logic [3:0]      w_id;
    logic [WB_W-1:0] w_beat;
    logic            w_err, w_ok, w_take;

    function automatic logic in_range(input logic [7:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    // Out-of-range reads return zero data with the error flag set
    assign r_addr_nxt = r_addr + 8'd1;
    always_comb begin
        rd_cur = 9'h001;
        rd_nxt = 9'h001;
        if (in_range(r_addr))     rd_cur = {mem[r_addr[IDX_W-1:0]], 1'b0};
        if (in_range(r_addr_nxt)) rd_nxt = {mem[r_addr_nxt[IDX_W-1:0]], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (bus.ARVALID) r_next = R_ACK;
            R_ACK:   r_next = R_DATA;
            R_DATA:  if (bus.RREADY && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_id     <= '0;
            r_out    <= '0;
            r_last   <= 1'b0;
            r_id_out <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (bus.ARVALID) begin
                    r_addr <= bus.AR_IN[15:8];
                    r_len  <= bus.AR_IN[7:4];
                    r_id   <= bus.AR_IN[3:0];
                end
                R_ACK: begin
                    r_out    <= rd_cur;
                    r_last   <= (r_len == 4'd0);
                    r_id_out <= r_id;
                    r_beat   <= '0;
                end
                R_DATA: if (bus.RREADY) begin
                    if (r_last) begin
                        r_out  <= '0;
                        r_last <= 1'b0;
                    end else begin
                        // next beat is fetched at the transfer edge so beats stream back-to-back
                        r_addr <= r_addr_nxt;
                        r_beat <= r_beat + 4'd1;
                        r_out  <= rd_nxt;
                        r_last <= ((r_beat + 4'd1) == r_len);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_take = (w_state == W_DATA) && bus.WVALID;
    assign w_ok   = in_range(w_addr) && (w_beat < BEAT_LIM);

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (bus.AWVALID) w_next = W_ACK;
            W_ACK:   w_next = W_DATA;
            W_DATA:  if (w_take && bus.WLAST) w_next = W_RESP;
            W_RESP:  if (bus.BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr <= '0;
            w_id   <= '0;
            w_beat <= '0;
            w_err  <= 1'b0;
        end else if (w_state == W_IDLE && bus.AWVALID) begin
            w_addr <= bus.AW_IN[11:4];
            w_id   <= bus.AW_IN[3:0];
            w_beat <= '0;
            w_err  <= 1'b0;
        end else if (w_take) begin
            w_addr <= w_addr + 8'd1;
            if (w_beat != BEAT_LIM) w_beat <= w_beat + 1'b1;
            if (!w_ok)              w_err  <= 1'b1;
        end
    end

    // Memory has no reset so contents survive a bus reset
    always_ff @(posedge clk) begin
        if (!rst && w_take && w_ok) mem[w_addr[IDX_W-1:0]] <= bus.WDATA;
    end

    always_comb begin
        bus.ARREADY = (r_state == R_ACK);
        bus.RVALID  = (r_state == R_DATA);
        bus.ROUT    = r_out;
        bus.RLAST   = r_last;
        bus.RID     = r_id_out;
        bus.AWREADY = (w_state == W_ACK);
        bus.WREADY  = (w_state == W_DATA);
        bus.BVALID  = (w_state == W_RESP);
        bus.BRESP   = (w_state == W_RESP) ? {w_id, w_err} : 5'd0;
    end
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// tb/tb_axi_lite_slave_mem.sv - directed bench for axi_lite_slave_mem (full depth and 8-byte instances)
module tb_axi_lite_slave_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic [15:0] ar_in = '0;
    logic [11:0] aw_in = '0;
    logic [7:0]  wdata = '0;

    logic [7:0] exp_mem [0:255];
    logic [7:0] wq [0:31];
    int vectors = 0;
    int miscompares = 0;

    axi_lite_slave_mem_if ifa ();
    axi_lite_slave_mem_if ifb ();

    assign ifa.ARVALID = arvalid;  assign ifb.ARVALID = arvalid;
    assign ifa.AR_IN   = ar_in;    assign ifb.AR_IN   = ar_in;
    assign ifa.RREADY  = rready;   assign ifb.RREADY  = rready;
    assign ifa.AWVALID = awvalid;  assign ifb.AWVALID = awvalid;
    assign ifa.AW_IN   = aw_in;    assign ifb.AW_IN   = aw_in;
    assign ifa.WVALID  = wvalid;   assign ifb.WVALID  = wvalid;
    assign ifa.WDATA   = wdata;    assign ifb.WDATA   = wdata;
    assign ifa.WLAST   = wlast;    assign ifb.WLAST   = wlast;
    assign ifa.BREADY  = bready;   assign ifb.BREADY  = bready;

    axi_lite_slave_mem #(.MEM_DEPTH(256), .MAX_BEATS(16)) dut (.clk(clk), .rst(rst), .bus(ifa.slave));
    axi_lite_slave_mem #(.MEM_DEPTH(8),   .MAX_BEATS(16)) dut_small (.clk(clk), .rst(rst), .bus(ifb.slave));

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                           input logic [3:0] patt);
        int n;
        int k;
        logic [7:0] a;
        @(posedge clk); #1 arvalid = 1'b1; ar_in = {addr, len, id};
        @(posedge clk); #1 arvalid = 1'b0; rready = 1'b0;
        @(negedge clk);
        check_vec("arready", 32'(ifa.ARREADY), 32'd1);
        check_vec("rvalid_early", 32'(ifa.RVALID), 32'd0);
        n = 0; k = 0; a = addr;
        @(posedge clk);
        while (n <= int'(len) && k < 200) begin
            #1 rready = patt[k % 4];
            @(negedge clk);
            if (k == 0) check_vec("arready_pulse", 32'(ifa.ARREADY), 32'd0);
            check_vec("rvalid", 32'(ifa.RVALID), 32'd1);
            if (ifa.RVALID !== 1'b1) break;
            check_vec("rout", 32'(ifa.ROUT), 32'({exp_mem[a], 1'b0}));
            check_vec("rout_small", 32'(ifb.ROUT), (a < 8'd8) ? 32'({exp_mem[a], 1'b0}) : 32'd1);
            check_vec("rlast", 32'(ifa.RLAST), 32'(n == int'(len)));
            check_vec("rid", 32'(ifa.RID), 32'(id));
            if (rready) begin
                n++;
                a++;
            end
            k++;
            @(posedge clk);
        end
        check_vec("rbeats", 32'(n), 32'(int'(len) + 1));
        #1 rready = 1'b0;
        @(negedge clk);
        check_vec("rvalid_end", 32'(ifa.RVALID), 32'd0);
        check_vec("rout_end", 32'(ifa.ROUT), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [3:0] id, input int nbeats);
        logic [7:0] a;
        logic err_a, err_b;
        @(posedge clk); #1 awvalid = 1'b1; aw_in = {addr, id};
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk);
        check_vec("awready", 32'(ifa.AWREADY), 32'd1);
        check_vec("wready_early", 32'(ifa.WREADY), 32'd0);
        a = addr; err_a = 1'b0; err_b = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            @(posedge clk); #1 wvalid = 1'b1; wdata = wq[i]; wlast = (i == nbeats - 1);
            @(negedge clk);
            if (i == 0) check_vec("awready_pulse", 32'(ifa.AWREADY), 32'd0);
            check_vec("wready", 32'(ifa.WREADY), 32'd1);
            if (i < 16) exp_mem[a] = wq[i];
            else        err_a = 1'b1;
            if (i >= 16 || a >= 8'd8) err_b = 1'b1;
            a++;
        end
        @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        check_vec("wready_end", 32'(ifa.WREADY), 32'd0);
        check_vec("bvalid", 32'(ifa.BVALID), 32'd1);
        check_vec("bresp", 32'(ifa.BRESP), 32'({id, err_a}));
        check_vec("bresp_small", 32'(ifb.BRESP), 32'({id, err_b}));
        @(posedge clk); #1 bready = 1'b1;
        @(negedge clk);
        check_vec("bvalid_hold", 32'(ifa.BVALID), 32'd1);
        check_vec("bresp_hold", 32'(ifa.BRESP), 32'({id, err_a}));
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        check_vec("bvalid_clr", 32'(ifa.BVALID), 32'd0);
        check_vec("bresp_clr", 32'(ifa.BRESP), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check_vec({tag, "_arready"}, 32'(ifa.ARREADY), 32'd0);
        check_vec({tag, "_rvalid"},  32'(ifa.RVALID),  32'd0);
        check_vec({tag, "_rout"},    32'(ifa.ROUT),    32'd0);
        check_vec({tag, "_rlast"},   32'(ifa.RLAST),   32'd0);
        check_vec({tag, "_rid"},     32'(ifa.RID),     32'd0);
        check_vec({tag, "_awready"}, 32'(ifa.AWREADY), 32'd0);
        check_vec({tag, "_wready"},  32'(ifa.WREADY),  32'd0);
        check_vec({tag, "_bvalid"},  32'(ifa.BVALID),  32'd0);
        check_vec({tag, "_bresp"},   32'(ifa.BRESP),   32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1 rst = 1'b0;

        wq[0] = 8'hA1; wq[1] = 8'hB2; wq[2] = 8'hC3;
        do_write(8'h10, 4'h5, 3);
        do_read(8'h10, 4'd2, 4'h3, 4'b1111);

        wq[0] = 8'h5A; wq[1] = 8'h6B;
        do_write(8'h07, 4'h1, 2);
        do_read(8'h07, 4'd1, 4'h4, 4'b1111);

        wq[0] = 8'hE1; wq[1] = 8'hF0;
        do_write(8'hFF, 4'h6, 2);
        do_read(8'hFF, 4'd1, 4'h8, 4'b1111);

        wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33; wq[3] = 8'h44;
        do_write(8'h20, 4'h2, 4);
        do_read(8'h20, 4'd3, 4'h1, 4'b1001);

        wq[0] = 8'h77; wq[1] = 8'h88;
        do_write(8'h50, 4'h1, 2);
        for (int i = 0; i < 18; i++) wq[i] = 8'(8'h80 + i);
        fork
            do_write(8'h40, 4'hA, 18);
            do_read(8'h10, 4'd2, 4'h3, 4'b1111);
        join
        do_read(8'h4E, 4'd3, 4'h2, 4'b1111);

        // reset while a 5-beat read and a write burst are both in flight
        @(posedge clk); #1 arvalid = 1'b1; ar_in = {8'h10, 4'd4, 4'h7};
        awvalid = 1'b1; aw_in = {8'h60, 4'h2}; rready = 1'b1;
        @(posedge clk); #1 arvalid = 1'b0; awvalid = 1'b0;
        @(posedge clk); #1 wvalid = 1'b1; wdata = 8'h99;
        @(posedge clk); #1 wvalid = 1'b0; exp_mem[8'h60] = 8'h99;
        @(negedge clk);
        check_vec("mid_rout", 32'(ifa.ROUT), 32'({8'hB2, 1'b0}));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; arvalid = 1'b1; ar_in = {8'h10, 4'd0, 4'h9};
        @(negedge clk);
        check_idle("midrst");
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk);
        check_vec("post_rst_arready", 32'(ifa.ARREADY), 32'd1);
        @(negedge clk);
        check_vec("post_rst_rvalid", 32'(ifa.RVALID), 32'd1);
        check_vec("post_rst_rout", 32'(ifa.ROUT), 32'({8'hA1, 1'b0}));
        check_vec("post_rst_rlast", 32'(ifa.RLAST), 32'd1);
        check_vec("post_rst_rid", 32'(ifa.RID), 32'h9);
        @(negedge clk);
        check_vec("post_rst_done", 32'(ifa.RVALID), 32'd0);
        rready = 1'b0;
        do_read(8'h60, 4'd0, 4'h2, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
